// File: rtl/wb_arbiter21_if.sv
// Two requester write ports plus the arbitrated write-back port, bundled for the 2:1 arbiter.
// The arbiter uses the slave view; the requesters and downstream consumer use the master view.
interface wb_arbiter21_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              mux_sel;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_src;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output mux_sel,
      output out_valid, out_addr, out_data, out_src,
      input  out_ready
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  mux_sel,
      input  out_valid, out_addr, out_data, out_src,
      output out_ready
   );
endinterface

// File: rtl/wb_arbiter21.sv
// Round-robin 2:1 arbiter for the register-file write-back port, with a one-entry
// output register and valid/ready handshakes on both sides.
module wb_arbiter21 #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 5,
   parameter int PRIORITY_INIT = 0,
   parameter int DROP_ZERO     = 1
) (
   input logic           clk,
   input logic           reset,
   wb_arbiter21_if.slave bus
);
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_src_q,   out_src_d;
   logic              prio_q,      prio_d;

   logic              load_en;
   logic              any_req;
   logic              gnt_idx;
   logic              sel;
   logic              accept;
   logic              drop;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // The register can take a new entry when it is empty or being drained this cycle.
   assign load_en = !out_valid_q || bus.out_ready;
   assign any_req = bus.req0_valid || bus.req1_valid;

   // A lone requester always wins; on a tie the rotating priority decides.
   assign gnt_idx = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
   assign sel     = any_req ? gnt_idx : prio_q;
   assign accept  = any_req && load_en && !reset;

   assign sel_addr = sel ? bus.req1_addr : bus.req0_addr;
   assign sel_data = sel ? bus.req1_data : bus.req0_data;
   assign drop     = (DROP_ZERO != 0) && (sel_addr == '0);

   assign bus.mux_sel    = sel;
   assign bus.req0_ready = accept && !gnt_idx;
   assign bus.req1_ready = accept &&  gnt_idx;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_src    = out_src_q;

   // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      out_valid_d = out_valid_q && !bus.out_ready;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      prio_d      = prio_q;
      if (accept) begin
         prio_d = !gnt_idx;
         // A discarded write-to-zero still completes its handshake but leaves the register empty.
         if (drop) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b1;
            out_addr_d  = sel_addr;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_src_q   <= 1'b0;
         prio_q      <= 1'(PRIORITY_INIT);
      end else begin
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         prio_q      <= prio_d;
      end
   end
endmodule

// File: tb/tb_wb_arbiter21.sv
// Self-checking bench for wb_arbiter21: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_arbiter21;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int PI     = 0;
   localparam int DZ     = 1;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   bit   hs0, hs1;

   wb_arbiter21_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_arbiter21 #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRIORITY_INIT(PI), .DROP_ZERO(DZ)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: the register contents and the rotating priority, advanced once per cycle.
   logic              m_valid = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [DATA_W-1:0] m_data  = '0;
   logic              m_src   = 1'b0;
   logic              m_prio  = 1'(PI);

   always @(negedge clk) begin
      int   win;
      logic room;
      logic e_sel, e_r0, e_r1;
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;

      if (bus.req0_valid && bus.req1_valid) win = int'(m_prio);
      else if (bus.req0_valid)              win = 0;
      else if (bus.req1_valid)              win = 1;
      else                                  win = -1;
      room  = !m_valid || bus.out_ready;
      e_sel = (win < 0) ? m_prio : (win == 1);
      e_r0  = !reset && room && (win == 0);
      e_r1  = !reset && room && (win == 1);

      check("mux_sel", bus.mux_sel, e_sel);
      check("req0_ready", bus.req0_ready, e_r0);
      check("req1_ready", bus.req1_ready, e_r1);
      check("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
         check("out_addr", bus.out_addr, m_addr);
         check("out_data", bus.out_data, m_data);
         check("out_src", bus.out_src, m_src);
      end

      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;

      if (reset) begin
         m_valid = 1'b0; m_addr = '0; m_data = '0; m_src = 1'b0; m_prio = 1'(PI);
      end else if (e_r0 || e_r1) begin
         w_addr = e_r1 ? bus.req1_addr : bus.req0_addr;
         w_data = e_r1 ? bus.req1_data : bus.req0_data;
         m_prio = e_r0;
         if (DZ != 0 && w_addr == 0) begin
            m_valid = 1'b0;
         end else begin
            m_valid = 1'b1; m_addr = w_addr; m_data = w_data; m_src = e_r1;
         end
      end else if (bus.out_ready && m_valid) begin
         m_valid = 1'b0;
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      bus.out_ready  = 1'b0;

      // Reset with no requests.
      repeat (3) step();
      check("t1_out_valid", bus.out_valid, 0);
      check("t1_mux_sel", bus.mux_sel, PI);
      check("t1_req0_ready", bus.req0_ready, 0);
      check("t1_req1_ready", bus.req1_ready, 0);
      check("t1_out_addr", bus.out_addr, 0);
      check("t1_out_data", bus.out_data, 0);
      check("t1_out_src", bus.out_src, 0);
      reset = 1'b0;

      // Single request from requester 0.
      bus.out_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h1;
      #1;
      check("t2_req0_ready", bus.req0_ready, 1);
      check("t2_req1_ready", bus.req1_ready, 0);
      step();
      bus.req0_valid = 1'b0;
      #1;
      check("t2_out_valid", bus.out_valid, 1);
      check("t2_out_addr", bus.out_addr, 3);
      check("t2_out_data", bus.out_data, 32'h1);
      check("t2_out_src", bus.out_src, 0);
      check("t2_prio", bus.mux_sel, 1);

      // Both requesting continuously: grants alternate starting from requester 0.
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hA;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'hB;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t3_req0_ready", bus.req0_ready, (k % 2) == 0);
         check("t3_req1_ready", bus.req1_ready, (k % 2) == 1);
         if (k > 0) check("t3_out_data", bus.out_data, ((k % 2) == 1) ? 32'hA : 32'hB);
         step();
      end

      // Backpressure for 4 cycles, then the next entry loads on the draining edge.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t4_req0_ready", bus.req0_ready, 0);
         check("t4_req1_ready", bus.req1_ready, 0);
         check("t4_out_valid", bus.out_valid, 1);
         check("t4_out_data", bus.out_data, 32'hB);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      check("t4_release_req0_ready", bus.req0_ready, 1);
      check("t4_release_req1_ready", bus.req1_ready, 0);
      step();
      #1;
      check("t4_next_out_data", bus.out_data, 32'hA);
      check("t4_next_out_src", bus.out_src, 0);
      check("t4_next_out_valid", bus.out_valid, 1);

      // Write to address 0 from requester 1 is accepted and discarded.
      bus.req0_valid = 1'b0;
      bus.req1_addr = 5'd0; bus.req1_data = 32'hFF;
      #1;
      check("t5_req1_ready", bus.req1_ready, 1);
      check("t5_req0_ready", bus.req0_ready, 0);
      step();
      bus.req1_valid = 1'b0;
      #1;
      check("t5_out_valid", bus.out_valid, 0);
      check("t5_prio", bus.mux_sel, 0);

      // Reset while holding an entry with both requesting.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
      bus.out_ready = 1'b0;
      step();
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      #1;
      check("t6_pre_out_valid", bus.out_valid, 1);
      check("t6_rst_req0_ready", bus.req0_ready, 0);
      check("t6_rst_req1_ready", bus.req1_ready, 0);
      step();
      #1;
      check("t6_out_valid", bus.out_valid, 0);
      check("t6_prio", bus.mux_sel, PI);
      reset = 1'b0;
      #1;
      check("t6_after_req0_ready", bus.req0_ready, 1);
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // Randomized traffic; requesters hold each request until its handshake.
      for (int c = 0; c < 3000; c++) begin
         step();
         if (hs0) bus.req0_valid = 1'b0;
         if (hs1) bus.req1_valid = 1'b0;
         if (!bus.req0_valid && $urandom_range(0, 2) != 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.req0_data  = $urandom;
         end
         if (!bus.req1_valid && $urandom_range(0, 2) != 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.req1_data  = $urandom;
         end
         bus.out_ready = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
